// File: rtl/yapay_zeka_komut_siralayici.sv
`default_nettype none
// ============================================================================
// Module   : yapay_zeka_komut_siralayici
// Function : X-instruction FIFO and issue sequencer for yapay_zeka_hizlandiricisi.
//            Optional RUN watchdog: define YAPAY_ZEKA_ZAMAN_ASIMI_EN.
// Revision : 1.0
// ============================================================================
module yapay_zeka_komut_siralayici #(
  parameter int FIFO_DERINLIK = 4,
  parameter int RUN_SINIR     = 32
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        ddb_durdur_i,
  input  logic        temizle_i,
  input  logic        istek_gecerli_i,
  output logic        istek_hazir_o,
  input  logic [2:0]  istek_kontrol_i,
  input  logic        istek_rs2_en_i,
  input  logic [31:0] istek_deger1_i,
  input  logic [31:0] istek_deger2_i,
  output logic [2:0]  yzh_kontrol_o,
  output logic        yzh_basla_o,
  output logic        yzh_rs2_en_o,
  output logic [31:0] yzh_deger1_o,
  output logic [31:0] yzh_deger2_o,
  input  logic        yzh_bitti_i,
  output logic        run_bitti_o,
  output logic        bos_o,
  output logic        hata_o
);

  // Only LD_W (reset value) and RUN need decoding; other opcodes pass through.
  localparam logic [2:0] c_YZH_LD_W = 3'd0;
  localparam logic [2:0] c_YZH_RUN  = 3'd4;

  localparam logic [1:0] c_BOSTA  = 2'd0;
  localparam logic [1:0] c_GONDER = 2'd1;
  localparam logic [1:0] c_CALIS  = 2'd2;

  localparam int ADRES_W = $clog2(FIFO_DERINLIK);
  localparam int SAYI_W  = ADRES_W + 1;
  localparam int KOMUT_W = 68;

  logic [KOMUT_W-1:0] r_mem [FIFO_DERINLIK];
  logic [ADRES_W-1:0] r_yaz;
  logic [ADRES_W-1:0] r_oku;
  logic [SAYI_W-1:0]  r_sayi;
  logic [1:0]         r_durum;
  logic [2:0]         r_kontrol;
  logic               r_basla;
  logic               r_rs2_en;
  logic [31:0]        r_deger1;
  logic [31:0]        r_deger2;
  logic               r_run_bitti;

  logic               w_bos;
  logic               w_dolu;
  logic               w_calis;
  logic               w_yaz_istek;
  logic               w_serbest;
  logic               w_pop;
  logic               w_birak;
  logic               w_fifo_yaz;
  logic               w_fifo_oku;
  logic               w_zaman_asimi;
  logic [KOMUT_W-1:0] w_gelen;
  logic [KOMUT_W-1:0] w_sonraki;

  if ((FIFO_DERINLIK < 2) || ((FIFO_DERINLIK & (FIFO_DERINLIK - 1)) != 0) || (RUN_SINIR < 1))
  begin : g_parametre_hatasi
    $error("yapay_zeka_komut_siralayici: FIFO_DERINLIK must be a power of 2 >= 2, RUN_SINIR >= 1");
  end

  assign w_bos       = (r_sayi == '0);
  assign w_dolu      = (r_sayi == SAYI_W'(FIFO_DERINLIK));
  assign w_calis     = (r_durum == c_CALIS);
  assign w_yaz_istek = istek_gecerli_i && !w_dolu && !temizle_i;
  assign w_gelen     = {istek_kontrol_i, istek_rs2_en_i, istek_deger1_i, istek_deger2_i};

  // An empty FIFO lets the incoming request issue straight away (one-cycle latency).
  assign w_serbest  = !temizle_i && !ddb_durdur_i && (!w_calis || yzh_bitti_i);
  assign w_pop      = w_serbest && (!w_bos || w_yaz_istek);
  assign w_sonraki  = w_bos ? w_gelen : r_mem[r_oku];
  assign w_fifo_yaz = w_yaz_istek && !(w_pop && w_bos);
  assign w_fifo_oku = w_pop && !w_bos;
  assign w_birak    = (w_serbest && !w_pop) || w_zaman_asimi;

`ifdef YAPAY_ZEKA_ZAMAN_ASIMI_EN
  localparam int SAYAC_W = $clog2(RUN_SINIR + 1);

  logic [SAYAC_W-1:0] r_sayac;
  logic               r_hata;

  assign w_zaman_asimi = w_calis && !ddb_durdur_i && !yzh_bitti_i && !temizle_i &&
                         (r_sayac == SAYAC_W'(RUN_SINIR - 1));
  assign hata_o        = r_hata;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_sayac <= '0;
      r_hata  <= 1'b0;
    end else if (temizle_i) begin
      r_sayac <= '0;
      r_hata  <= 1'b0;
    end else begin
      r_hata <= w_zaman_asimi;
      if (w_pop) begin
        r_sayac <= '0;
      end else if (w_calis && !ddb_durdur_i) begin
        r_sayac <= r_sayac + SAYAC_W'(1);
      end
    end
  end
`else
  assign w_zaman_asimi = 1'b0;
  assign hata_o        = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (w_fifo_yaz) begin
      r_mem[r_yaz] <= w_gelen;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_yaz       <= '0;
      r_oku       <= '0;
      r_sayi      <= '0;
      r_durum     <= c_BOSTA;
      r_kontrol   <= c_YZH_LD_W;
      r_basla     <= 1'b0;
      r_rs2_en    <= 1'b0;
      r_deger1    <= '0;
      r_deger2    <= '0;
      r_run_bitti <= 1'b0;
    end else if (temizle_i) begin
      r_yaz       <= '0;
      r_oku       <= '0;
      r_sayi      <= '0;
      r_durum     <= c_BOSTA;
      r_basla     <= 1'b0;
      r_run_bitti <= 1'b0;
    end else begin
      r_run_bitti <= w_calis && yzh_bitti_i && !ddb_durdur_i;
      if (w_fifo_yaz) begin
        r_yaz <= r_yaz + ADRES_W'(1);
      end
      if (w_fifo_oku) begin
        r_oku <= r_oku + ADRES_W'(1);
      end
      r_sayi <= r_sayi + SAYI_W'(w_fifo_yaz) - SAYI_W'(w_fifo_oku);
      if (w_pop) begin
        {r_kontrol, r_rs2_en, r_deger1, r_deger2} <= w_sonraki;
        r_basla <= 1'b1;
        r_durum <= (w_sonraki[KOMUT_W-1 -: 3] == c_YZH_RUN) ? c_CALIS : c_GONDER;
      end else if (w_birak) begin
        r_basla <= 1'b0;
        r_durum <= c_BOSTA;
      end
    end
  end

  assign istek_hazir_o = !w_dolu;
  assign bos_o         = w_bos && (r_durum == c_BOSTA);
  assign yzh_kontrol_o = r_kontrol;
  assign yzh_basla_o   = r_basla;
  assign yzh_rs2_en_o  = r_rs2_en;
  assign yzh_deger1_o  = r_deger1;
  assign yzh_deger2_o  = r_deger2;
  assign run_bitti_o   = r_run_bitti;

endmodule
`default_nettype wire

// File: tb/tb_yapay_zeka_komut_siralayici.sv
`default_nettype none
// ============================================================================
// Module   : tb_yapay_zeka_komut_siralayici
// Function : Directed + random bench with a queue-level reference model.
// Revision : 1.0
// ============================================================================
module tb_yapay_zeka_komut_siralayici;

  localparam int D     = 4;
  localparam int SINIR = 32;

  localparam logic [2:0] OP_LD_W = 3'd0;
  localparam logic [2:0] OP_LD_X = 3'd1;
  localparam logic [2:0] OP_RUN  = 3'd4;

  typedef struct packed {
    logic [2:0]  op;
    logic        rs2;
    logic [31:0] d1;
    logic [31:0] d2;
  } komut_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        durdur;
  logic        temizle;
  logic        istek_gecerli;
  logic        istek_hazir;
  logic [2:0]  istek_kontrol;
  logic        istek_rs2;
  logic [31:0] istek_d1;
  logic [31:0] istek_d2;
  logic [2:0]  yzh_kontrol;
  logic        yzh_basla;
  logic        yzh_rs2;
  logic [31:0] yzh_d1;
  logic [31:0] yzh_d2;
  logic        yzh_bitti;
  logic        run_bitti;
  logic        bos;
  logic        hata;

  yapay_zeka_komut_siralayici #(
    .FIFO_DERINLIK (D),
    .RUN_SINIR     (SINIR)
  ) u_dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .ddb_durdur_i    (durdur),
    .temizle_i       (temizle),
    .istek_gecerli_i (istek_gecerli),
    .istek_hazir_o   (istek_hazir),
    .istek_kontrol_i (istek_kontrol),
    .istek_rs2_en_i  (istek_rs2),
    .istek_deger1_i  (istek_d1),
    .istek_deger2_i  (istek_d2),
    .yzh_kontrol_o   (yzh_kontrol),
    .yzh_basla_o     (yzh_basla),
    .yzh_rs2_en_o    (yzh_rs2),
    .yzh_deger1_o    (yzh_d1),
    .yzh_deger2_o    (yzh_d2),
    .yzh_bitti_i     (yzh_bitti),
    .run_bitti_o     (run_bitti),
    .bos_o           (bos),
    .hata_o          (hata)
  );

  always #5 clk = ~clk;

  // Accelerator model: done on the 16th non-stalled RUN cycle, unless stuck.
  int acc_cnt;
  bit acc_takili = 1'b0;
  assign yzh_bitti = !acc_takili && yzh_basla && (yzh_kontrol == OP_RUN) && (acc_cnt == 15);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_cnt <= 0;
    end else if (temizle) begin
      acc_cnt <= 0;
    end else if (yzh_basla && (yzh_kontrol == OP_RUN)) begin
      if (!durdur) acc_cnt <= yzh_bitti ? 0 : acc_cnt + 1;
    end else begin
      acc_cnt <= 0;
    end
  end

  int run_say = 0;
  int rb_say  = 0;
  always @(posedge clk) begin
    if (rst_n && !temizle && yzh_basla && (yzh_kontrol == OP_RUN) && !durdur) run_say <= run_say + 1;
    if (run_bitti) rb_say <= rb_say + 1;
  end

  // Reference model: pending queue plus the command currently shown to the accelerator.
  komut_t m_q[$];
  komut_t m_act;
  bit     m_basla, m_rb, m_hata, m_kabul;
  int     m_tsay;

  int n_vec  = 0;
  int n_hata = 0;

  function automatic void model_reset();
    m_q.delete();
    m_act   = '{op: OP_LD_W, rs2: 1'b0, d1: 32'h0, d2: 32'h0};
    m_basla = 1'b0;
    m_rb    = 1'b0;
    m_hata  = 1'b0;
    m_kabul = 1'b0;
    m_tsay  = 0;
  endfunction

  function automatic void model_adim(bit g, komut_t c, bit dur, bit tem, bit bitti);
    bit al;
    m_rb    = 1'b0;
    m_hata  = 1'b0;
    m_kabul = 1'b0;
    if (tem) begin
      m_q.delete();
      m_basla = 1'b0;
      return;
    end
    if (g && (m_q.size() < D)) begin
      m_q.push_back(c);
      m_kabul = 1'b1;
    end
    if (!dur) begin
      al = 1'b1;
      if (m_basla && (m_act.op == OP_RUN)) begin
        if (bitti) begin
          m_rb = 1'b1;
        end else begin
          al = 1'b0;
`ifdef YAPAY_ZEKA_ZAMAN_ASIMI_EN
          m_tsay++;
          if (m_tsay >= SINIR) begin
            m_basla = 1'b0;
            m_hata  = 1'b1;
          end
`endif
        end
      end
      if (al) begin
        if (m_q.size() > 0) begin
          m_act   = m_q.pop_front();
          m_basla = 1'b1;
          m_tsay  = 0;
        end else begin
          m_basla = 1'b0;
        end
      end
    end
  endfunction

  task automatic kontrol(input string tag);
    logic [72:0] gozlenen, beklenen;
    gozlenen = {yzh_kontrol, yzh_basla, yzh_rs2, yzh_d1, yzh_d2, run_bitti, bos, hata, istek_hazir};
    beklenen = {m_act.op, m_basla, m_act.rs2, m_act.d1, m_act.d2, m_rb,
                (m_q.size() == 0) && !m_basla, m_hata, m_q.size() < D};
    n_vec++;
    assert (gozlenen === beklenen)
    else begin
      n_hata++;
      $error("FAIL %s: observed %h expected %h (kontrol,basla,rs2,d1,d2,run_bitti,bos,hata,hazir)",
             tag, gozlenen, beklenen);
    end
  endtask

  task automatic kontrol_int(input string tag, input int gozlenen, input int beklenen);
    n_vec++;
    assert (gozlenen === beklenen)
    else begin
      n_hata++;
      $error("FAIL %s: observed %0d expected %0d", tag, gozlenen, beklenen);
    end
  endtask

  // Called just after a falling edge with inputs already applied.
  task automatic tick(input string tag);
    #1;
    model_adim(istek_gecerli, {istek_kontrol, istek_rs2, istek_d1, istek_d2}, durdur, temizle, yzh_bitti);
    @(posedge clk);
    @(negedge clk);
    kontrol(tag);
  endtask

  task automatic bosta(input int n, input string tag);
    for (int i = 0; i < n; i++) tick(tag);
  endtask

  task automatic gonder(input logic [2:0] op, input logic rs2, input logic [31:0] a,
                        input logic [31:0] b, input string tag);
    int n;
    n = 0;
    istek_gecerli = 1'b1;
    istek_kontrol = op;
    istek_rs2     = rs2;
    istek_d1      = a;
    istek_d2      = b;
    do begin
      tick(tag);
      n++;
    end while (!m_kabul && (n < 100));
    kontrol_int({tag, "_kabul"}, int'(m_kabul), 1);
    istek_gecerli = 1'b0;
  endtask

  initial begin
    int s_run, s_rb;
    rst_n         = 1'b0;
    durdur        = 1'b0;
    temizle       = 1'b0;
    istek_gecerli = 1'b0;
    istek_kontrol = OP_LD_W;
    istek_rs2     = 1'b0;
    istek_d1      = 32'h0;
    istek_d2      = 32'h0;
    model_reset();

    @(negedge clk);
    @(negedge clk);
    kontrol("reset");
    rst_n = 1'b1;

    // Single LD_W issued one cycle after the request, then basla drops.
    gonder(OP_LD_W, 1'b1, 32'h11, 32'h22, "ldw");
    bosta(3, "ldw_sonra");

    // Back-to-back LD_X at one per cycle.
    for (int i = 0; i < 4; i++) gonder(OP_LD_X, 1'b0, 32'hA0 + i, 32'hB0 + i, "ldx_seri");
    bosta(2, "ldx_sonra");

    // RUN occupies 16 basla cycles and pulses run_bitti once.
    s_run = run_say;
    s_rb  = rb_say;
    gonder(OP_RUN, 1'b0, 32'h5, 32'h6, "run");
    bosta(20, "run_bekle");
    kontrol_int("run_basla_say", run_say - s_run, 16);
    kontrol_int("run_bitti_say", rb_say - s_rb, 1);

    // RUN plus five LD_X: queue fills, fifth waits for RUN completion.
    gonder(OP_RUN, 1'b0, 32'h7, 32'h8, "run_dolu");
    for (int i = 0; i < 5; i++) gonder(OP_LD_X, 1'b1, 32'hC0 + i, 32'hD0 + i, "dolu_ldx");
    bosta(8, "dolu_bosalt");

    // Three stalled cycles inside a RUN.
    s_run = run_say;
    gonder(OP_RUN, 1'b0, 32'h9, 32'hA, "run_durdur");
    bosta(4, "run_durdur_once");
    durdur = 1'b1;
    bosta(3, "run_durdur_aktif");
    durdur = 1'b0;
    bosta(15, "run_durdur_sonra");
    kontrol_int("run_durdur_say", run_say - s_run, 16);

    // Flush mid-RUN with a concurrent push: dropped, no run_bitti.
    s_rb = rb_say;
    gonder(OP_RUN, 1'b0, 32'hB, 32'hC, "run_temizle");
    gonder(OP_LD_X, 1'b0, 32'hE1, 32'hE2, "temizle_kuyruk");
    bosta(3, "temizle_once");
    temizle       = 1'b1;
    istek_gecerli = 1'b1;
    istek_kontrol = OP_CLR_X_val();
    tick("temizle");
    temizle       = 1'b0;
    istek_gecerli = 1'b0;
    bosta(20, "temizle_sonra");
    kontrol_int("temizle_run_bitti", rb_say - s_rb, 0);

    // Accelerator never finishes.
    acc_takili = 1'b1;
    gonder(OP_RUN, 1'b0, 32'hF0, 32'hF1, "takili");
    gonder(OP_LD_W, 1'b1, 32'hF2, 32'hF3, "takili_kuyruk");
    bosta(36, "takili_bekle");
`ifdef YAPAY_ZEKA_ZAMAN_ASIMI_EN
    kontrol_int("takili_basla", int'(yzh_kontrol == OP_RUN && yzh_basla), 0);
`else
    kontrol_int("takili_basla", int'(yzh_kontrol == OP_RUN && yzh_basla), 1);
`endif
    temizle = 1'b1;
    tick("takili_temizle");
    temizle    = 1'b0;
    acc_takili = 1'b0;
    bosta(2, "takili_sonra");

    // Random traffic.
    for (int i = 0; i < 500; i++) begin
      istek_gecerli = ($urandom_range(0, 1) == 1);
      istek_kontrol = ($urandom_range(0, 9) < 2) ? OP_RUN : 3'($urandom_range(0, 3));
      istek_rs2     = 1'($urandom);
      istek_d1      = $urandom;
      istek_d2      = $urandom;
      durdur        = ($urandom_range(0, 99) < 15);
      temizle       = ($urandom_range(0, 99) < 2);
      tick("rastgele");
    end
    istek_gecerli = 1'b0;
    durdur        = 1'b0;
    temizle       = 1'b0;
    bosta(40, "rastgele_son");

    // Asynchronous reset in the middle of a RUN.
    gonder(OP_RUN, 1'b0, 32'h33, 32'h44, "run_reset");
    bosta(4, "run_reset_once");
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    kontrol("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    gonder(OP_LD_X, 1'b1, 32'h55, 32'h66, "reset_sonra");
    bosta(2, "reset_sonra_bos");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_hata);
    $finish;
  end

  function automatic logic [2:0] OP_CLR_X_val();
    return 3'd3;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, observed no finish, required finish");
    $fatal(1, "time limit");
  end

endmodule
`default_nettype wire
